// File: rtl/sap1_control_sequencer.sv
// rtl/sap1_control_sequencer.sv - SAP-1 microcode step counter and control strobe decoder
module sap1_control_sequencer #(
    parameter int OPCODE_WIDTH = 4,
    parameter int STEP_WIDTH   = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clk_en,
    input  logic [OPCODE_WIDTH-1:0] i_opcode,
    input  logic                    i_carry,
    input  logic                    i_zero,
    output logic [STEP_WIDTH-1:0]   o_step,
    output logic                    o_pc_out,
    output logic                    o_pc_inc,
    output logic                    o_pc_load,
    output logic                    o_mar_load,
    output logic                    o_ram_out,
    output logic                    o_ram_write,
    output logic                    o_ir_load,
    output logic                    o_ir_out,
    output logic                    o_a_load,
    output logic                    o_a_out,
    output logic                    o_b_load,
    output logic                    o_alu_out,
    output logic                    o_alu_sub,
    output logic                    o_flags_load,
    output logic                    o_out_load,
    output logic                    o_halt
);

    typedef enum logic [STEP_WIDTH-1:0] {
        T0 = STEP_WIDTH'(0),
        T1 = STEP_WIDTH'(1),
        T2 = STEP_WIDTH'(2),
        T3 = STEP_WIDTH'(3),
        T4 = STEP_WIDTH'(4)
    } step_t;

    localparam logic [OPCODE_WIDTH-1:0] OP_LDA = OPCODE_WIDTH'(1);
    localparam logic [OPCODE_WIDTH-1:0] OP_ADD = OPCODE_WIDTH'(2);
    localparam logic [OPCODE_WIDTH-1:0] OP_SUB = OPCODE_WIDTH'(3);
    localparam logic [OPCODE_WIDTH-1:0] OP_STA = OPCODE_WIDTH'(4);
    localparam logic [OPCODE_WIDTH-1:0] OP_LDI = OPCODE_WIDTH'(5);
    localparam logic [OPCODE_WIDTH-1:0] OP_JMP = OPCODE_WIDTH'(6);
    localparam logic [OPCODE_WIDTH-1:0] OP_JC  = OPCODE_WIDTH'(7);
    localparam logic [OPCODE_WIDTH-1:0] OP_JZ  = OPCODE_WIDTH'(8);
    localparam logic [OPCODE_WIDTH-1:0] OP_OUT = OPCODE_WIDTH'(14);
    localparam logic [OPCODE_WIDTH-1:0] OP_HLT = OPCODE_WIDTH'(15);

    step_t step;
    step_t last_step;
    logic  halt_reg;
    logic  hlt_at_t2;

    assign hlt_at_t2 = (step == T2) && (i_opcode == OP_HLT);

    // Final execute step per opcode; NOP, undefined and single-step ops end at T2.
    always_comb begin
        last_step = T2;
        case (i_opcode)
            OP_LDA, OP_STA: last_step = T3;
            OP_ADD, OP_SUB: last_step = T4;
            default:        last_step = T2;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            step     <= T0;
            halt_reg <= 1'b0;
        end else if (clk_en && !halt_reg) begin
            if (hlt_at_t2) begin
                halt_reg <= 1'b1;
            end else if (step == last_step) begin
                step <= T0;
            end else begin
                case (step)
                    T0:      step <= T1;
                    T1:      step <= T2;
                    T2:      step <= T3;
                    T3:      step <= T4;
                    default: step <= T0;
                endcase
            end
        end
    end

    always_comb begin
        o_pc_out     = 1'b0;
        o_pc_inc     = 1'b0;
        o_pc_load    = 1'b0;
        o_mar_load   = 1'b0;
        o_ram_out    = 1'b0;
        o_ram_write  = 1'b0;
        o_ir_load    = 1'b0;
        o_ir_out     = 1'b0;
        o_a_load     = 1'b0;
        o_a_out      = 1'b0;
        o_b_load     = 1'b0;
        o_alu_out    = 1'b0;
        o_alu_sub    = 1'b0;
        o_flags_load = 1'b0;
        o_out_load   = 1'b0;
        if (!halt_reg) begin
            case (step)
                T0: begin
                    o_pc_out   = 1'b1;
                    o_mar_load = 1'b1;
                end
                T1: begin
                    o_ram_out = 1'b1;
                    o_ir_load = 1'b1;
                    o_pc_inc  = 1'b1;
                end
                T2: begin
                    case (i_opcode)
                        OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
                            o_ir_out   = 1'b1;
                            o_mar_load = 1'b1;
                        end
                        OP_LDI: begin
                            o_ir_out = 1'b1;
                            o_a_load = 1'b1;
                        end
                        OP_JMP: begin
                            o_ir_out  = 1'b1;
                            o_pc_load = 1'b1;
                        end
                        OP_JC: begin
                            o_ir_out  = i_carry;
                            o_pc_load = i_carry;
                        end
                        OP_JZ: begin
                            o_ir_out  = i_zero;
                            o_pc_load = i_zero;
                        end
                        OP_OUT: begin
                            o_a_out    = 1'b1;
                            o_out_load = 1'b1;
                        end
                        default: ;
                    endcase
                end
                T3: begin
                    case (i_opcode)
                        OP_LDA: begin
                            o_ram_out = 1'b1;
                            o_a_load  = 1'b1;
                        end
                        OP_ADD, OP_SUB: begin
                            o_ram_out = 1'b1;
                            o_b_load  = 1'b1;
                        end
                        OP_STA: begin
                            o_a_out     = 1'b1;
                            o_ram_write = 1'b1;
                        end
                        default: ;
                    endcase
                end
                T4: begin
                    if (i_opcode == OP_ADD || i_opcode == OP_SUB) begin
                        o_alu_out    = 1'b1;
                        o_a_load     = 1'b1;
                        o_flags_load = 1'b1;
                        o_alu_sub    = (i_opcode == OP_SUB);
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_halt = halt_reg | hlt_at_t2;
    assign o_step = step;

endmodule

// File: tb/tb_sap1_control_sequencer.sv
// tb/tb_sap1_control_sequencer.sv - scoreboard bench for sap1_control_sequencer
module tb_sap1_control_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       clk_en;
    logic [3:0] i_opcode;
    logic       i_carry;
    logic       i_zero;
    logic [2:0] o_step;
    logic o_pc_out, o_pc_inc, o_pc_load, o_mar_load, o_ram_out, o_ram_write;
    logic o_ir_load, o_ir_out, o_a_load, o_a_out, o_b_load, o_alu_out;
    logic o_alu_sub, o_flags_load, o_out_load, o_halt;

    sap1_control_sequencer #(.OPCODE_WIDTH(4), .STEP_WIDTH(3)) dut (
        .clk(clk), .rst(rst), .clk_en(clk_en), .i_opcode(i_opcode),
        .i_carry(i_carry), .i_zero(i_zero), .o_step(o_step),
        .o_pc_out(o_pc_out), .o_pc_inc(o_pc_inc), .o_pc_load(o_pc_load),
        .o_mar_load(o_mar_load), .o_ram_out(o_ram_out), .o_ram_write(o_ram_write),
        .o_ir_load(o_ir_load), .o_ir_out(o_ir_out), .o_a_load(o_a_load),
        .o_a_out(o_a_out), .o_b_load(o_b_load), .o_alu_out(o_alu_out),
        .o_alu_sub(o_alu_sub), .o_flags_load(o_flags_load),
        .o_out_load(o_out_load), .o_halt(o_halt)
    );

    always #5 clk = ~clk;

    localparam logic [15:0] PCO  = 16'h8000, PCI  = 16'h4000, PCL  = 16'h2000;
    localparam logic [15:0] MAR  = 16'h1000, RAMO = 16'h0800, RAMW = 16'h0400;
    localparam logic [15:0] IRL  = 16'h0200, IRO  = 16'h0100, AL   = 16'h0080;
    localparam logic [15:0] AO   = 16'h0040, BL   = 16'h0020, ALUO = 16'h0010;
    localparam logic [15:0] ASUB = 16'h0008, FL   = 16'h0004, OUTL = 16'h0002;
    localparam logic [15:0] HLT  = 16'h0001;

    typedef struct packed {
        logic [2:0]  step;
        logic [15:0] mask;
        logic [3:0]  op;
        logic        c;
        logic        z;
    } exp_t;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    function automatic logic [18:0] observed();
        return {o_step, o_pc_out, o_pc_inc, o_pc_load, o_mar_load, o_ram_out,
                o_ram_write, o_ir_load, o_ir_out, o_a_load, o_a_out, o_b_load,
                o_alu_out, o_alu_sub, o_flags_load, o_out_load, o_halt};
    endfunction

    task automatic check(input string tag, input logic [18:0] obs, input logic [18:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_invariants();
        int drivers;
        drivers = int'(o_pc_out) + int'(o_ram_out) + int'(o_ir_out) + int'(o_a_out) + int'(o_alu_out);
        check("bus_onehot", 19'(drivers <= 1), 19'd1);
        check("pc_inc_load", 19'(o_pc_inc & o_pc_load), 19'd0);
    endtask

    task automatic push(input logic [2:0] s, input logic [15:0] m, input logic [3:0] op,
                        input logic c, input logic z);
        exp_t e;
        e.step = s; e.mask = m; e.op = op; e.c = c; e.z = z;
        q.push_back(e);
    endtask

    // Expected microsequence; fetch steps carry a scrambled opcode when asked, since it is ignored there.
    task automatic push_instr(input logic [3:0] op, input logic c, input logic z, input bit scramble);
        logic [3:0] f0, f1;
        f0 = scramble ? 4'($urandom_range(0, 15)) : op;
        f1 = scramble ? 4'($urandom_range(0, 15)) : op;
        push(3'd0, PCO | MAR, f0, c, z);
        push(3'd1, RAMO | IRL | PCI, f1, c, z);
        case (op)
            4'd1: begin push(3'd2, IRO | MAR, op, c, z); push(3'd3, RAMO | AL, op, c, z); end
            4'd2, 4'd3: begin
                push(3'd2, IRO | MAR, op, c, z);
                push(3'd3, RAMO | BL, op, c, z);
                push(3'd4, ALUO | AL | FL | ((op == 4'd3) ? ASUB : 16'h0), op, c, z);
            end
            4'd4:  begin push(3'd2, IRO | MAR, op, c, z); push(3'd3, AO | RAMW, op, c, z); end
            4'd5:  push(3'd2, IRO | AL, op, c, z);
            4'd6:  push(3'd2, IRO | PCL, op, c, z);
            4'd7:  push(3'd2, c ? (IRO | PCL) : 16'h0, op, c, z);
            4'd8:  push(3'd2, z ? (IRO | PCL) : 16'h0, op, c, z);
            4'd14: push(3'd2, AO | OUTL, op, c, z);
            4'd15: push(3'd2, HLT, op, c, z);
            default: push(3'd2, 16'h0, op, c, z);
        endcase
    endtask

    // mode 0: clk_en every cycle, 1: every 3rd cycle, 2: random gaps
    task automatic run_queue(input int mode, input int limit);
        exp_t e;
        int   gaps;
        int   done = 0;
        while (q.size() > 0 && done < limit) begin
            e = q.pop_front();
            done++;
            i_opcode = e.op; i_carry = e.c; i_zero = e.z;
            gaps = (mode == 0) ? 0 : (mode == 1) ? 2 : int'($urandom_range(0, 2));
            for (int g = 0; g <= gaps; g++) begin
                clk_en = (g == gaps);
                @(negedge clk);
                check("strobes", observed(), {e.step, e.mask});
                check_invariants();
                @(posedge clk);
                #1;
            end
        end
    endtask

    initial begin
        rst = 1'b1; clk_en = 1'b0; i_opcode = 4'd0; i_carry = 1'b0; i_zero = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_decode", observed(), {3'd0, PCO | MAR});
        @(posedge clk); #1;
        rst = 1'b0;

        foreach (q[i]) q.delete(i);
        push_instr(4'd0, 0, 0, 0);
        push_instr(4'd5, 0, 0, 0);
        push_instr(4'd1, 0, 0, 0);
        push_instr(4'd4, 0, 0, 0);
        push_instr(4'd2, 0, 0, 0);
        push_instr(4'd3, 0, 0, 0);
        push_instr(4'd14, 0, 0, 0);
        push_instr(4'd6, 0, 0, 0);
        push_instr(4'd7, 0, 0, 0);
        push_instr(4'd7, 1, 0, 0);
        push_instr(4'd8, 0, 0, 0);
        push_instr(4'd8, 0, 1, 0);
        push_instr(4'd11, 0, 0, 0);
        run_queue(0, 1000);

        push_instr(4'd2, 0, 0, 0);
        run_queue(1, 1000);

        push_instr(4'd2, 0, 0, 0);
        run_queue(0, 3);
        i_opcode = 4'd2;
        #2 rst = 1'b1;
        #1 check("async_reset", observed(), {3'd0, PCO | MAR});
        q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        push_instr(4'd5, 0, 0, 0);
        run_queue(0, 1000);

        push_instr(4'd15, 0, 0, 0);
        for (int k = 0; k < 22; k++) push(3'd2, HLT, 4'($urandom_range(0, 15)), 1'($urandom), 1'($urandom));
        run_queue(0, 1000);
        rst = 1'b1;
        #1 check("halt_cleared", observed(), {3'd0, PCO | MAR});
        @(posedge clk); #1;
        rst = 1'b0;

        for (int n = 0; n < 1400; n++) begin
            push_instr(4'($urandom_range(0, 14)), 1'($urandom), 1'($urandom), 1);
            run_queue(2, 1000);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sap1_control_sequencer.md
Name: sap1_control_sequencer

Overview:
Microcode controller for the SAP-1 CPU. It generates every datapath control strobe each cycle, including increment, load and halt for the program counter. A step counter runs fetch (T0–T1) followed by opcode-dependent execute steps (T2–T4), and returns to T0 immediately after each instruction's final step. It sits between the instruction register, flags register and datapath, and is gated by the shared clk_en.

Parameters:
OPCODE_WIDTH, 4, width of the opcode field from the instruction register; only 4 is supported.
STEP_WIDTH, 3, width of the step counter; must hold 0–4.

Ports:
clk  input  1  system clock
rst  input  1  asynchronous reset, active-high
clk_en  input  1  global clock enable; state advances only when high
i_opcode  input  OPCODE_WIDTH  upper nibble of the instruction register
i_carry  input  1  registered carry flag
i_zero  input  1  registered zero flag
o_step  output  STEP_WIDTH  current microstep, for debug
o_pc_out  output  1  PC drives bus
o_pc_inc  output  1  PC counter enable
o_pc_load  output  1  PC load from bus
o_mar_load  output  1  memory address register load
o_ram_out  output  1  RAM drives bus
o_ram_write  output  1  RAM write from bus
o_ir_load  output  1  IR load
o_ir_out  output  1  IR operand (low nibble) drives bus
o_a_load  output  1  A register load
o_a_out  output  1  A register drives bus
o_b_load  output  1  B register load
o_alu_out  output  1  ALU drives bus
o_alu_sub  output  1  ALU subtract select
o_flags_load  output  1  flags register load
o_out_load  output  1  output register load
o_halt  output  1  halt; feeds PC i_halt and stops all sequencing

Behaviour:
- Interface: one clock, clk; reset rst is asynchronous and active-high.
- State: step register (0–4) and halt_reg.
- Reset: step=0, halt_reg=0, effective immediately on rst assertion, including mid-instruction. Outputs after reset show the T0 decode: o_pc_out=1, o_mar_load=1, all other strobes 0, o_step=0, o_halt=0.
- All strobes are combinational decodes of step, i_opcode, i_carry, i_zero and halt_reg. Zero latency: a strobe is valid during its step and acts at the next clk edge where clk_en=1.
- Step advances only on a clk edge with clk_en=1 and halt_reg=0. The step after the final step is 0. Otherwise step increments by 1.
- Fetch, identical for all opcodes:
  - T0: pc_out, mar_load.
  - T1: ram_out, ir_load, pc_inc.
- Execute, by opcode:
  - 0 NOP: T2 no strobes; last step T2.
  - 1 LDA: T2 ir_out, mar_load; T3 ram_out, a_load; last step T3.
  - 2 ADD: T2 ir_out, mar_load; T3 ram_out, b_load; T4 alu_out, a_load, flags_load; last step T4.
  - 3 SUB: same as ADD, plus alu_sub in T4.
  - 4 STA: T2 ir_out, mar_load; T3 a_out, ram_write; last step T3.
  - 5 LDI: T2 ir_out, a_load; last step T2.
  - 6 JMP: T2 ir_out, pc_load; last step T2.
  - 7 JC: T2 ir_out, pc_load only if i_carry=1, otherwise no strobes; last step T2.
  - 8 JZ: as JC, using i_zero.
  - 14 OUT: T2 a_out, out_load; last step T2.
  - 15 HLT: T2 o_halt=1; halt_reg is set at the next clk_en edge.
  - 9–13 (undefined): behave as NOP.
- i_opcode is ignored at T0 and T1, because the IR is still loading.
- Halt:
  - o_halt = halt_reg OR (step==2 AND opcode==HLT).
  - Once halt_reg=1, step freezes at 2 and all strobes except o_halt are 0.
  - Only rst clears halt_reg.
- Invariants:
  - At most one *_out bus driver is asserted in any cycle.
  - o_pc_inc and o_pc_load are never asserted together.
  - No strobe is ever X after reset.
- clk_en=0: state holds and combinational outputs remain stable. Downstream blocks gate on clk_en themselves.

Test Plan:
- Reset, then opcodes NOP, LDI, LDA, STA, ADD, SUB, OUT, JMP and HLT each run with clk_en=1 every cycle → strobes per step exactly as tabulated. ADD takes 5 cycles from T0 back to T0; LDI takes 3.
- JC with i_carry=0 then 1, and JZ with i_zero=0 then 1 → o_pc_load is asserted in T2 only when the flag is 1; step returns to 0 after T2 in both cases.
- clk_en asserted every 3rd cycle during ADD → step advances only on enabled edges; strobes are held constant between enabled edges.
- HLT → o_halt rises in T2 and stays high for 20+ cycles; step stays at 2; all other strobes are 0. Then rst → step=0, o_halt=0, o_pc_out=1.
- rst asserted asynchronously (between edges) at ADD T3 → outputs show the T0 decode before the next clk edge; after release, the next instruction fetch is normal.
- Randomized opcodes, flags and clk_en for 10k cycles → the bus-driver one-hot invariant holds, no pc_inc and pc_load overlap occurs, and undefined opcodes take 3 cycles.
